// File: rtl/and_gate_pkg.sv
// Shared constants and types for the and_gate block.
package and_gate_pkg;

   // Default operand width.
   localparam int AND_GATE_WIDTH = 1;

   // Number of bit-0 truth-table rows tracked by the coverage flags.
   localparam int MINTERM_COUNT = 4;

   // Index of a bit-0 truth-table row, encoded as {a[0], b[0]}.
   typedef enum logic [1:0] {
      MT_A0_B0 = 2'b00,
      MT_A0_B1 = 2'b01,
      MT_A1_B0 = 2'b10,
      MT_A1_B1 = 2'b11
   } minterm_idx_t;

   // Builds the minterm index from the low bits of the two operands.
   function automatic minterm_idx_t to_minterm(input logic a0, input logic b0);
      return minterm_idx_t'({a0, b0});
   endfunction

endpackage : and_gate_pkg

// File: rtl/and_gate.sv
// Bitwise AND with a combinational output, a registered output with valid,
// reduction flags on the registered result, and sticky bit-0 truth-table
// coverage flags.
module and_gate
   import and_gate_pkg::*;
#(
   parameter int WIDTH = AND_GATE_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         a,
   input  logic [WIDTH-1:0]         b,
   input  logic                     in_valid,
   output logic [WIDTH-1:0]         out,
   output logic [WIDTH-1:0]         out_q,
   output logic                     out_valid,
   output logic                     all_ones,
   output logic                     any_ones,
   output logic [MINTERM_COUNT-1:0] seen,
   output logic                     cov_done
);

   logic [WIDTH-1:0]         w_and;
   minterm_idx_t             w_idx;

   logic [WIDTH-1:0]         r_out_q;
   logic                     r_out_valid;
   logic [MINTERM_COUNT-1:0] r_seen;

   // Pure gate path: no clock or reset involvement, X/Z follow operator rules.
   assign w_and = a & b;
   assign w_idx = to_minterm(a[0], b[0]);
   assign out   = w_and;

   // Registered result, valid pulse and sticky coverage; reset wins over in_valid.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_out_q     <= '0;
         r_out_valid <= 1'b0;
         r_seen      <= '0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_out_q       <= w_and;
            r_seen[w_idx] <= 1'b1;
         end
      end
   end

   // Status flags derived from the registered state only.
   always_comb begin
      all_ones = &r_out_q;
      any_ones = |r_out_q;
      cov_done = &r_seen;
   end

   assign out_q     = r_out_q;
   assign out_valid = r_out_valid;
   assign seen      = r_seen;

endmodule : and_gate

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: one WIDTH=1 and one WIDTH=4 instance
// share stimulus (the narrow one sees bit 0); a queue-based scoreboard holds
// expected registered state until the edge that produces it.
module tb_and_gate;

   localparam int W4 = 4;

   typedef struct packed {
      logic [W4-1:0] q;
      logic          v;
      logic [3:0]    seen;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [W4-1:0] a4, b4;
   logic          a1, b1;

   logic [W4-1:0] out4, out_q4;
   logic          out_valid4, all_ones4, any_ones4, cov_done4;
   logic [3:0]    seen4;
   logic          out1, out_q1;
   logic          out_valid1, all_ones1, any_ones1, cov_done1;
   logic [3:0]    seen1;

   int            errors = 0;
   int            checks = 0;

   exp_t          sb[$];
   logic [W4-1:0] m_q;
   logic [3:0]    m_seen;

   and_gate #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(in_valid),
      .out(out1), .out_q(out_q1), .out_valid(out_valid1),
      .all_ones(all_ones1), .any_ones(any_ones1),
      .seen(seen1), .cov_done(cov_done1)
   );

   and_gate #(.WIDTH(W4)) dut4 (
      .clk(clk), .rst(rst), .a(a4), .b(b4), .in_valid(in_valid),
      .out(out4), .out_q(out_q4), .out_valid(out_valid4),
      .all_ones(all_ones4), .any_ones(any_ones4),
      .seen(seen4), .cov_done(cov_done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", tag, act, exp);
      end
   endtask

   // One clock of stimulus: drive at negedge, check comb path, model the edge,
   // then pop and compare the registered outputs just after the edge.
   task automatic cycle(input logic [W4-1:0] a, input logic [W4-1:0] b,
                        input logic v, input logic r);
      exp_t e;
      @(negedge clk);
      a4 = a; b4 = b; a1 = a[0]; b1 = b[0]; in_valid = v; rst = r;
      #1;
      check("out4_comb", 64'(out4), 64'(a & b));
      check("out1_comb", 64'(out1), 64'(a[0] & b[0]));
      if (r) begin
         m_q = '0; m_seen = '0; e.v = 1'b0;
      end else begin
         e.v = v;
         if (v) begin
            m_q = a & b;
            m_seen[{a[0], b[0]}] = 1'b1;
         end
      end
      e.q = m_q; e.seen = m_seen;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("out_q4",     64'(out_q4),     64'(e.q));
      check("out_valid4", 64'(out_valid4), 64'(e.v));
      check("seen4",      64'(seen4),      64'(e.seen));
      check("all_ones4",  64'(all_ones4),  64'(&e.q));
      check("any_ones4",  64'(any_ones4),  64'(|e.q));
      check("cov_done4",  64'(cov_done4),  64'(&e.seen));
      check("out_q1",     64'(out_q1),     64'(e.q[0]));
      check("out_valid1", 64'(out_valid1), 64'(e.v));
      check("seen1",      64'(seen1),      64'(e.seen));
      check("all1_any1",  64'({all_ones1, any_ones1}), 64'({e.q[0], e.q[0]}));
      check("out4_post",  64'(out4),       64'(a & b));
   endtask

   initial begin
      logic [3:0] cov_exp [4];
      logic       tt_exp  [4];
      logic [1:0] tt_idx;
      cov_exp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
      tt_exp  = '{1'b0, 1'b0, 1'b0, 1'b1};
      m_q = '0; m_seen = '0;
      rst = 1'b1; in_valid = 1'b0; a4 = '0; b4 = '0; a1 = 1'b0; b1 = 1'b0;

      // Combinational truth table while held in reset.
      for (int i = 0; i < 4; i++) begin
         tt_idx = 2'(i);
         a1 = tt_idx[1]; b1 = tt_idx[0];
         #10;
         check("tt_out1", 64'(out1), 64'(tt_exp[i]));
      end
      a1 = 1'b0; b1 = 1'bx;
      #1;
      check("x_and_zero", 64'(out1), 64'(1'b0));

      // Reset state, then first edge with rst=0 samples the input.
      cycle(4'h0, 4'h0, 1'b1, 1'b1);
      cycle(4'h1, 4'h1, 1'b1, 1'b0);
      check("first_q", 64'(out_q1), 64'(1'b1));
      cycle(4'h1, 4'h0, 1'b1, 1'b0);
      check("second_q", 64'(out_q1), 64'(1'b0));

      // Coverage fill in row order after a fresh reset.
      cycle(4'h0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tt_idx = 2'(i);
         cycle({3'b000, tt_idx[1]}, {3'b000, tt_idx[0]}, 1'b1, 1'b0);
         check("cov_seq", 64'(seen4), 64'(cov_exp[i]));
      end
      check("cov_done", 64'(cov_done1), 64'(1'b1));

      // Reset beats a valid input in the same cycle; comb out unaffected.
      cycle(4'h1, 4'h1, 1'b1, 1'b1);
      check("rst_seen", 64'(seen1), 64'(4'b0000));
      check("rst_out",  64'(out1),  64'(1'b1));

      // Multi-bit reductions.
      cycle(4'b1011, 4'b1101, 1'b1, 1'b0);
      check("w4_q", 64'(out_q4), 64'(4'b1001));
      cycle(4'hF, 4'hF, 1'b1, 1'b0);
      check("w4_all", 64'(all_ones4), 64'(1'b1));

      // Hold: inputs toggle with in_valid low.
      cycle(4'h5, 4'hF, 1'b0, 1'b0);
      cycle(4'hA, 4'h3, 1'b0, 1'b0);
      cycle(4'h0, 4'h0, 1'b0, 1'b0);
      check("hold_q", 64'(out_q4), 64'(4'hF));

      // Back-to-back random traffic with occasional gaps.
      for (int i = 0; i < 40; i++)
         cycle(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0);

      check("sb_empty", 64'(sb.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_and_gate

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1: operand width in bits, legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  WIDTH  operand A.
REQ-005 b  input  WIDTH  operand B.
REQ-006 in_valid  input  1  qualifies a/b for the registered path and coverage tracking.
REQ-007 out  output  WIDTH  combinational bitwise AND of a and b.
REQ-008 out_q  output  WIDTH  registered AND result.
REQ-009 out_valid  output  1  high the cycle after an accepted input.
REQ-010 all_ones  output  1  reduction AND of out_q.
REQ-011 any_ones  output  1  reduction OR of out_q.
REQ-012 seen  output  4  sticky bit-0 truth-table coverage flags, index = {a[0],b[0]}.
REQ-013 cov_done  output  1  high when all four seen flags are set.

Function
REQ-014 out SHALL equal a & b bitwise at all times, zero latency, independent of clk, rst and in_valid.
REQ-015 out SHALL propagate X/Z per standard AND semantics (0 & X = 0).
REQ-016 On a rising edge with in_valid=1 and rst=0, out_q SHALL load a & b.
REQ-017 With in_valid=0, out_q SHALL hold its previous value.
REQ-018 out_valid SHALL register in_valid: one-cycle latency, no back-pressure, one pulse per accepted input.
REQ-019 all_ones and any_ones SHALL be combinational from out_q; for WIDTH=1 both equal out_q.
REQ-020 On an accepted input, seen[{a[0],b[0]}] SHALL be set and stay set until reset.
REQ-021 cov_done SHALL be the AND of seen[3:0], combinational from seen.
REQ-022 Back-to-back accepted inputs SHALL each update out_q and seen with no lost cycle.

Reset
REQ-023 While rst=1 at a rising edge, out_q, out_valid and seen SHALL all clear to 0; all_ones, any_ones and cov_done follow as 0.
REQ-024 rst SHALL take priority over in_valid in the same cycle; that input is discarded.
REQ-025 rst SHALL NOT affect the combinational out.
REQ-026 The first accepted input SHALL be sampled on the first edge with rst=0.

Structure
REQ-027 A shared package and_gate_pkg SHALL hold the WIDTH default constant and the 2-bit minterm index type.
REQ-028 The design SHALL be a single module with no sub-modules.

Verification
REQ-029 WIDTH=1, comb only, 10 time units per step: (a,b) = 00, 01, 10, 11 -> out = 0, 0, 0, 1.
REQ-030 Registered path, in_valid=1: apply a=1, b=1 -> next cycle out_q=1, out_valid=1, all_ones=1, any_ones=1; then a=1, b=0 -> out_q=0.
REQ-031 Coverage: the four combinations are applied with in_valid=1 -> seen goes 0001, 0011, 0111, 1111 and cov_done=1 after the fourth.
REQ-032 Reset mid-operation: seen=1111, then rst=1 with in_valid=1, a=1, b=1 -> out_q=0, out_valid=0, seen=0000; out stays 1.
REQ-033 WIDTH=4: a=4'b1011, b=4'b1101 -> out=4'b1001, all_ones=0, any_ones=1; a=b=4'hF -> all_ones=1.
REQ-034 Hold: in_valid=0 while a and b toggle -> out_q, out_valid=0 and seen remain unchanged, and out tracks a & b.
